// File: rtl/spi_slave_responder.sv
// SPI mode-0 target oversampled on sys_clk_i, with valid/ready tx/rx word streams.
// Optional SPI_SLV_ECHO_EN: an empty tx holding register echoes the last received word instead of IDLE_PATTERN.
module spi_slave_responder #(
   parameter int unsigned       DATA_W       = 8,
   parameter logic [DATA_W-1:0] IDLE_PATTERN = {DATA_W{1'b1}},
   parameter int unsigned       SYNC_STAGES  = 2
) (
   input  logic              sys_clk_i,
   input  logic              rstn_i,
   input  logic              spi_clk_i,
   input  logic              spi_csn_i,
   input  logic              spi_sdo_i,
   output logic              spi_sdi_o,
   output logic              spi_sdi_oe_o,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              tx_valid_i,
   output logic              tx_ready_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_valid_o,
   input  logic              rx_ready_i,
   output logic              frame_active_o,
   output logic              frame_end_o,
   output logic              tx_underrun_o,
   output logic              rx_overrun_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t state, state_next;

   logic [SYNC_STAGES-1:0] clk_sync, csn_sync, sdo_sync;
   logic clk_d, csn_d;
   logic sck_s, csn_s, sdo_s;
   logic sck_rise, sck_fall, csn_fall, csn_rise;

   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-2:0] rx_shift;
   logic [DATA_W-2:0] tx_rest;
   logic [DATA_W-1:0] hold_data;
   logic              hold_full;
   logic [DATA_W-1:0] rx_word;
   logic [DATA_W-1:0] load_word;
   logic              load_underrun;

   logic start_frame, stop_frame, sample, load, shift_tx, word_done;

`ifdef SPI_SLV_ECHO_EN
   logic [DATA_W-1:0] echo_data;
   logic              echo_valid;
`endif

   // Sync flops reset low so a CSN held low across reset never looks like a fresh fall.
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         clk_sync <= '0;
         csn_sync <= '0;
         sdo_sync <= '0;
         clk_d    <= 1'b0;
         csn_d    <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], spi_clk_i};
         csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
         sdo_sync <= {sdo_sync[SYNC_STAGES-2:0], spi_sdo_i};
         clk_d    <= clk_sync[SYNC_STAGES-1];
         csn_d    <= csn_sync[SYNC_STAGES-1];
      end
   end

   assign sck_s    = clk_sync[SYNC_STAGES-1];
   assign csn_s    = csn_sync[SYNC_STAGES-1];
   assign sdo_s    = sdo_sync[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~clk_d;
   assign sck_fall = ~sck_s & clk_d;
   assign csn_fall = ~csn_s & csn_d;
   assign csn_rise = csn_s & ~csn_d;

   assign rx_word   = {rx_shift, sdo_s};
   assign word_done = sample && (bit_cnt == LAST_BIT);

   // Source of the next tx word whenever the shifter reloads.
   always_comb begin
      load_word     = IDLE_PATTERN;
      load_underrun = 1'b1;
      if (hold_full) begin
         load_word     = hold_data;
         load_underrun = 1'b0;
      end
`ifdef SPI_SLV_ECHO_EN
      else if (echo_valid) begin
         load_word     = echo_data;
         load_underrun = 1'b0;
      end
`endif
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_next;
   end

   // A CSN rise takes priority over any SCK edge seen in the same cycle.
   always_comb begin
      state_next  = state;
      start_frame = 1'b0;
      stop_frame  = 1'b0;
      sample      = 1'b0;
      load        = 1'b0;
      shift_tx    = 1'b0;
      case (state)
         IDLE: begin
            if (csn_fall) begin
               state_next  = SHIFT;
               start_frame = 1'b1;
               load        = 1'b1;
            end
         end
         SHIFT: begin
            if (csn_rise) begin
               state_next = IDLE;
               stop_frame = 1'b1;
            end else if (sck_rise) begin
               sample = 1'b1;
            end else if (sck_fall) begin
               if (bit_cnt == '0) load = 1'b1;
               else               shift_tx = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         spi_sdi_o     <= 1'b0;
         spi_sdi_oe_o  <= 1'b0;
         bit_cnt       <= '0;
         rx_shift      <= '0;
         tx_rest       <= '0;
         hold_data     <= '0;
         hold_full     <= 1'b0;
         rx_data_o     <= '0;
         rx_valid_o    <= 1'b0;
         frame_end_o   <= 1'b0;
         tx_underrun_o <= 1'b0;
         rx_overrun_o  <= 1'b0;
      end else begin
         frame_end_o   <= 1'b0;
         tx_underrun_o <= 1'b0;
         rx_overrun_o  <= 1'b0;

         if (stop_frame) begin
            spi_sdi_o    <= 1'b0;
            spi_sdi_oe_o <= 1'b0;
            frame_end_o  <= 1'b1;
            bit_cnt      <= '0;
            rx_shift     <= '0;
         end
         if (start_frame) begin
            spi_sdi_oe_o <= 1'b1;
            bit_cnt      <= '0;
         end
         if (load) begin
            spi_sdi_o     <= load_word[DATA_W-1];
            tx_rest       <= load_word[DATA_W-2:0];
            tx_underrun_o <= load_underrun;
            hold_full     <= 1'b0;
         end
         if (shift_tx) begin
            spi_sdi_o <= tx_rest[DATA_W-2];
            tx_rest   <= {tx_rest[DATA_W-3:0], 1'b0};
         end
         if (sample) begin
            rx_shift <= rx_word[DATA_W-2:0];
            bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
         end

         // Accept is placed after the load so a same-cycle refill wins.
         if (tx_valid_i && !hold_full) begin
            hold_data <= tx_data_i;
            hold_full <= 1'b1;
         end

         if (word_done) begin
            if (!rx_valid_o || rx_ready_i) begin
               rx_data_o  <= rx_word;
               rx_valid_o <= 1'b1;
            end else begin
               rx_overrun_o <= 1'b1;
            end
         end else if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end
      end
   end

`ifdef SPI_SLV_ECHO_EN
   always_ff @(posedge sys_clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         echo_data  <= '0;
         echo_valid <= 1'b0;
      end else if (word_done) begin
         echo_data  <= rx_word;
         echo_valid <= 1'b1;
      end
   end
`endif

   assign tx_ready_o     = ~hold_full;
   assign frame_active_o = (state == SHIFT);

endmodule
